// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, buffered drawing writes
// and a full-frame clear engine fill the remaining slots.
module vram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 3,
  parameter int VRAM_WORDS = 76800,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(VRAM_WORDS - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  state_t            state;
  wr_entry_t         fifo_mem [FIFO_DEPTH];
  wr_entry_t         fifo_head;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level_next;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_color_q;
  logic              rd_pend;
  logic              push;
  logic              pop;
  logic              clr_step;
  logic              clr_last;

  // Writes are only accepted in IDLE, so buffered data never straddles a clear.
  assign wr_ready   = !p_reset && (state == IDLE) && (fifo_level != LVL_FULL);
  assign push       = wr_valid && wr_ready;
  assign clr_step   = (state == CLEAR) && !disp_req;
  assign pop        = ((state == IDLE) || (state == DRAIN)) && !disp_req && (fifo_level != '0);
  assign clr_last   = (clr_addr == CLR_LAST);
  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
  assign fifo_head  = fifo_mem[rd_ptr];

  // NOTE: the write buffer storage has no reset; the pointers and level alone
  // define which entries are meaningful.
  always_ff @(posedge m_clock) begin
    if (push) fifo_mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
  end

  // NOTE: all state updates are non-blocking so every term below sees the
  // pre-edge values, independent of statement order.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_level  <= '0;
      clr_addr    <= '0;
      clr_color_q <= '0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      rd_pend     <= 1'b0;
      disp_valid  <= 1'b0;
      disp_data   <= '0;
    end else begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      clr_done   <= 1'b0;
      clr_busy   <= (state != IDLE);
      fifo_level <= level_next;

      // Read return pipeline: command, RAM access, registered result.
      rd_pend    <= ram_en && !ram_we;
      disp_valid <= rd_pend;
      if (rd_pend) disp_data <= ram_rdata;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      if (disp_req) begin
        ram_en   <= 1'b1;
        ram_addr <= disp_addr;
      end else if (clr_step) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= clr_addr;
        ram_wdata <= clr_color_q;
      end else if (pop) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= fifo_head.addr;
        ram_wdata <= fifo_head.data;
      end

      unique case (state)
        IDLE: begin
          if (clr_start) begin
            clr_color_q <= clr_color;
            clr_busy    <= 1'b1;
            state       <= (level_next != '0) ? DRAIN : CLEAR;
          end
        end
        DRAIN: begin
          if (level_next == '0) state <= CLEAR;
        end
        CLEAR: begin
          if (clr_step) begin
            if (clr_last) begin
              clr_addr <= '0;
              clr_done <= 1'b1;
              state    <= IDLE;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: per-cycle vector table for fetch/write
// arbitration, hand sequences for clear, drain, and mid-clear reset.
module tb_vram_arbiter;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int TB_WORDS   = 300;
  localparam int N_VEC      = 25;

  logic              m_clock    = 1'b0;
  logic              p_reset    = 1'b1;
  logic              disp_req   = 1'b0;
  logic [ADDR_W-1:0] disp_addr  = '0;
  logic              wr_valid   = 1'b0;
  logic [ADDR_W-1:0] wr_addr    = '0;
  logic [DATA_W-1:0] wr_data    = '0;
  logic              clr_start  = 1'b0;
  logic [DATA_W-1:0] clr_color  = '0;
  logic [DATA_W-1:0] ram_rdata  = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              wr_ready;
  logic              clr_busy;
  logic              clr_done;
  logic [LVL_W-1:0]  fifo_level;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 m_clock = ~m_clock;

  vram_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .VRAM_WORDS(TB_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .fifo_level(fifo_level),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model: unwritten words read back as addr[2:0]^3'b101.
  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  bit                written [0:(1<<ADDR_W)-1];
  always @(posedge m_clock) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr]     = ram_wdata;
        written[ram_addr] = 1'b1;
      end else begin
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : (ram_addr[2:0] ^ 3'b101);
      end
    end
  end

  // Write log and clr_done bookkeeping, sampled mid-cycle.
  logic [ADDR_W+DATA_W-1:0] wlog[$];
  int done_cnt = 0;
  int done_bad = 0;
  always @(negedge m_clock) begin
    if (ram_en === 1'b1 && ram_we === 1'b1) wlog.push_back({ram_addr, ram_wdata});
    if (clr_done === 1'b1) begin
      done_cnt++;
      if (!(ram_en === 1'b1 && ram_we === 1'b1 && ram_addr == ADDR_W'(TB_WORDS - 1))) done_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic              dreq;
    logic [ADDR_W-1:0] daddr;
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              e_en;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    logic              e_dv;
    logic [DATA_W-1:0] e_dd;
    logic              e_wrdy;
    logic [LVL_W-1:0]  e_lvl;
  } vec_t;

  function automatic vec_t mk(input int dreq, input int daddr, input int wv, input int wa,
                              input int wd, input int en, input int we, input int ea,
                              input int ewd, input int dv, input int dd, input int wrdy,
                              input int lvl);
    vec_t r;
    r.dreq   = dreq[0];
    r.daddr  = ADDR_W'(daddr);
    r.wv     = wv[0];
    r.wa     = ADDR_W'(wa);
    r.wd     = DATA_W'(wd);
    r.e_en   = en[0];
    r.e_we   = we[0];
    r.e_addr = ADDR_W'(ea);
    r.e_wd   = DATA_W'(ewd);
    r.e_dv   = dv[0];
    r.e_dd   = DATA_W'(dd);
    r.e_wrdy = wrdy[0];
    r.e_lvl  = LVL_W'(lvl);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [N_VEC];
    int base, done_base, bad_base, done_at, viol, bad, dv_seen, n_exp;
    logic [ADDR_W+DATA_W-1:0] exp_w;

    //           inputs: dreq daddr  wv  wa    wd | expected: en we addr  wd  dv dd rdy lvl
    v[0]  = mk(1, 'h10, 0, 0,     0,   0, 0, 0,     0,  0, 0, 1, 0);
    v[1]  = mk(0, 0,    0, 0,     0,   1, 0, 'h10,  0,  0, 0, 1, 0);
    v[2]  = mk(0, 0,    0, 0,     0,   0, 0, 0,     0,  0, 0, 1, 0);
    v[3]  = mk(0, 0,    0, 0,     0,   0, 0, 0,     0,  1, 5, 1, 0);
    v[4]  = mk(1, 'h21, 1, 'h100, 1,   0, 0, 0,     0,  0, 5, 1, 0);
    v[5]  = mk(1, 'h21, 1, 'h101, 2,   1, 0, 'h21,  0,  0, 5, 1, 1);
    v[6]  = mk(1, 'h21, 1, 'h102, 3,   1, 0, 'h21,  0,  0, 5, 1, 2);
    v[7]  = mk(1, 'h21, 1, 'h103, 4,   1, 0, 'h21,  0,  1, 4, 1, 3);
    v[8]  = mk(1, 'h21, 1, 'h104, 5,   1, 0, 'h21,  0,  1, 4, 0, 4);
    v[9]  = mk(1, 'h21, 1, 'h104, 5,   1, 0, 'h21,  0,  1, 4, 0, 4);
    v[10] = mk(0, 0,    1, 'h104, 5,   1, 0, 'h21,  0,  1, 4, 0, 4);
    v[11] = mk(0, 0,    1, 'h104, 5,   1, 1, 'h100, 1,  1, 4, 1, 3);
    v[12] = mk(0, 0,    1, 'h105, 6,   1, 1, 'h101, 2,  1, 4, 1, 3);
    v[13] = mk(0, 0,    0, 0,     0,   1, 1, 'h102, 3,  0, 4, 1, 3);
    v[14] = mk(0, 0,    0, 0,     0,   1, 1, 'h103, 4,  0, 4, 1, 2);
    v[15] = mk(0, 0,    0, 0,     0,   1, 1, 'h104, 5,  0, 4, 1, 1);
    v[16] = mk(0, 0,    0, 0,     0,   1, 1, 'h105, 6,  0, 4, 1, 0);
    v[17] = mk(0, 0,    1, 'h200, 7,   0, 0, 0,     0,  0, 4, 1, 0);
    v[18] = mk(1, 'h33, 1, 'h201, 2,   0, 0, 0,     0,  0, 4, 1, 1);
    v[19] = mk(0, 0,    0, 0,     0,   1, 0, 'h33,  0,  0, 4, 1, 2);
    v[20] = mk(1, 'h34, 0, 0,     0,   1, 1, 'h200, 7,  0, 4, 1, 1);
    v[21] = mk(0, 0,    0, 0,     0,   1, 0, 'h34,  0,  1, 6, 1, 1);
    v[22] = mk(0, 0,    0, 0,     0,   1, 1, 'h201, 2,  0, 6, 1, 0);
    v[23] = mk(0, 0,    0, 0,     0,   0, 0, 0,     0,  1, 1, 1, 0);
    v[24] = mk(0, 0,    0, 0,     0,   0, 0, 0,     0,  0, 1, 1, 0);

    // Reset state
    repeat (2) @(negedge m_clock);
    check("rst ram_en", ram_en, 0);
    check("rst ram_we", ram_we, 0);
    check("rst disp_valid", disp_valid, 0);
    check("rst disp_data", disp_data, 0);
    check("rst wr_ready", wr_ready, 0);
    check("rst clr_busy", clr_busy, 0);
    check("rst clr_done", clr_done, 0);
    check("rst fifo_level", fifo_level, 0);
    p_reset = 1'b0;
    #1 check("post-rst wr_ready", wr_ready, 1);

    // Fetch latency, FIFO backpressure, push+pop, alternating slots
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge m_clock);
      check($sformatf("v%0d ram_en", i), ram_en, v[i].e_en);
      check($sformatf("v%0d ram_we", i), ram_we, v[i].e_we);
      if (v[i].e_en) check($sformatf("v%0d ram_addr", i), ram_addr, v[i].e_addr);
      if (v[i].e_we) check($sformatf("v%0d ram_wdata", i), ram_wdata, v[i].e_wd);
      check($sformatf("v%0d disp_valid", i), disp_valid, v[i].e_dv);
      check($sformatf("v%0d disp_data", i), disp_data, v[i].e_dd);
      check($sformatf("v%0d wr_ready", i), wr_ready, v[i].e_wrdy);
      check($sformatf("v%0d fifo_level", i), fifo_level, v[i].e_lvl);
      disp_req  = v[i].dreq;
      disp_addr = v[i].daddr;
      wr_valid  = v[i].wv;
      wr_addr   = v[i].wa;
      wr_data   = v[i].wd;
    end

    // Clear with three buffered writes, ignored restart and a fetch burst
    base      = wlog.size();
    done_base = done_cnt;
    bad_base  = done_bad;
    @(negedge m_clock);
    disp_req = 1'b1; disp_addr = 17'h50;
    wr_valid = 1'b1; wr_addr = 17'h300; wr_data = 3'd3;
    @(negedge m_clock);
    wr_addr = 17'h301; wr_data = 3'd4;
    @(negedge m_clock);
    wr_addr = 17'h302; wr_data = 3'd5;
    @(negedge m_clock);
    check("pre-clear fifo_level", fifo_level, 3);
    wr_valid = 1'b0; clr_start = 1'b1; clr_color = 3'b010;
    @(negedge m_clock);
    check("drain clr_busy", clr_busy, 1);
    check("drain wr_ready", wr_ready, 0);
    check("drain fifo_level", fifo_level, 3);
    clr_start = 1'b0; disp_req = 1'b0;
    done_at = 0;
    viol    = 0;
    for (int c = 1; c <= TB_WORDS + 60; c++) begin
      @(negedge m_clock);
      if (clr_done === 1'b1) begin
        done_at = c;
        break;
      end
      if (clr_busy !== 1'b1 || wr_ready !== 1'b0) viol++;
      clr_start = (c == 40);
      if (c == 40) clr_color = 3'b101;
      disp_req  = (c >= 100 && c < 103);
      disp_addr = ADDR_W'(32'hC0 + c);
    end
    clr_start = 1'b0; disp_req = 1'b0;
    check("clear1 clr_done seen", done_at != 0, 1);
    check("clear1 busy/ready violations", viol, 0);
    @(negedge m_clock);
    check("clear1 clr_busy falls", clr_busy, 0);
    check("clear1 wr_ready back", wr_ready, 1);
    n_exp = 3 + TB_WORDS;
    check("clear1 write count", wlog.size() - base, n_exp);
    bad = 0;
    for (int i = 0; i < n_exp && base + i < wlog.size(); i++) begin
      if (i < 3) exp_w = {ADDR_W'(32'h300 + i), DATA_W'(3 + i)};
      else       exp_w = {ADDR_W'(i - 3), 3'b010};
      if (wlog[base + i] !== exp_w) bad++;
    end
    check("clear1 write order errors", bad, 0);
    check("clear1 clr_done pulses", done_cnt - done_base, 1);
    check("clear1 clr_done off last addr", done_bad - bad_base, 0);

    // Reset mid-clear with two reads in flight
    @(negedge m_clock);
    clr_start = 1'b1; clr_color = 3'b110;
    @(negedge m_clock);
    clr_start = 1'b0;
    repeat (20) @(negedge m_clock);
    disp_req = 1'b1; disp_addr = 17'h41;
    @(negedge m_clock);
    disp_addr = 17'h42;
    @(negedge m_clock);
    disp_req = 1'b0;
    check("mid-clear clr_busy", clr_busy, 1);
    check("mid-clear read cmd", ram_en & ~ram_we, 1);
    #1 p_reset = 1'b1;
    #1;
    check("async rst ram_en", ram_en, 0);
    check("async rst ram_addr", ram_addr, 0);
    check("async rst ram_wdata", ram_wdata, 0);
    check("async rst disp_data", disp_data, 0);
    check("async rst clr_busy", clr_busy, 0);
    check("async rst wr_ready", wr_ready, 0);
    @(negedge m_clock);
    @(negedge m_clock);
    p_reset = 1'b0;
    dv_seen = 0;
    repeat (6) begin
      @(negedge m_clock);
      if (disp_valid !== 1'b0) dv_seen++;
    end
    check("no disp_valid after reset", dv_seen, 0);
    check("post-rst2 wr_ready", wr_ready, 1);
    check("post-rst2 fifo_level", fifo_level, 0);
    check("post-rst2 clr_busy", clr_busy, 0);

    // Minimum write latency from IDLE
    wr_valid = 1'b1; wr_addr = 17'h1234; wr_data = 3'd3;
    @(negedge m_clock);
    wr_valid = 1'b0;
    check("lat fifo_level", fifo_level, 1);
    check("lat no early write", ram_en, 0);
    @(negedge m_clock);
    check("lat ram_we", ram_we, 1);
    check("lat ram_addr", ram_addr, 17'h1234);
    check("lat ram_wdata", ram_wdata, 3);

    // Clear straight from IDLE: counter restarted at 0, exact duration
    @(negedge m_clock);
    clr_start = 1'b1; clr_color = 3'b011;
    done_at = 0;
    for (int c = 1; c <= TB_WORDS + 20; c++) begin
      @(negedge m_clock);
      if (c == 1) begin
        clr_start = 1'b0;
        check("clear2 entry busy", clr_busy, 1);
        check("clear2 entry no cmd", ram_en, 0);
      end
      if (c == 2) begin
        check("clear2 first we", ram_we, 1);
        check("clear2 first addr", ram_addr, 0);
        check("clear2 first data", ram_wdata, 3);
      end
      if (clr_done === 1'b1) begin
        done_at = c;
        break;
      end
    end
    clr_start = 1'b0;
    check("clear2 duration", done_at, TB_WORDS + 1);
    check("clear2 last addr", ram_addr, TB_WORDS - 1);
    check("clear2 busy at done", clr_busy, 1);
    @(negedge m_clock);
    check("clear2 busy falls", clr_busy, 0);
    check("clear2 done single", clr_done, 0);
    check("clear2 wr_ready back", wr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
